// File: rtl/tub_thresh_dac_loader.sv
// Serial loader for the TUB 12-bit threshold DAC (SCLK/SDI/LD_N).
// Optional periodic reload of CODE_OUT: define TUB_DAC_AUTO_REFRESH_EN.
module tub_thresh_dac_loader #(
  parameter int DATA_W      = 12,
  parameter int DIV         = 4,
  parameter int LD_CYC      = 2,
  parameter int REFRESH_CYC = 65536
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic              wr_drop,
  output logic [DATA_W-1:0] code_out,
  output logic              sclk,
  output logic              sdi,
  output logic              ld_n
);

  localparam int CMAX = (DIV > LD_CYC) ? DIV : LD_CYC;
  localparam int CW   = $clog2(CMAX + 1);
  localparam int BW   = $clog2(DATA_W + 1);

  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] LD_LAST   = CW'(LD_CYC - 1);
  localparam logic [BW-1:0] BITS_INIT = BW'(DATA_W);
  localparam logic [BW-1:0] BITS_ONE  = BW'(1);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    HIGH,
    LOAD
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] code_q;
  logic [DATA_W-1:0] nxt;
  logic [CW-1:0]     cnt;
  logic [BW-1:0]     bits;
  logic              host;
  logic              go_ref;

  assign nxt = shreg << 1;

`ifdef TUB_DAC_AUTO_REFRESH_EN
  localparam int IW = $clog2(REFRESH_CYC + 1);
  localparam logic [IW-1:0] IDLE_LAST = IW'(REFRESH_CYC - 1);

  logic [IW-1:0] idle_cnt;

  // A host write in the expiry cycle takes priority over the refresh.
  assign go_ref = (state == IDLE) && !wr && (idle_cnt == IDLE_LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      idle_cnt <= '0;
    end else if (state != IDLE || wr || go_ref) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + IW'(1);
    end
  end
`else
  assign go_ref = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      shreg    <= '0;
      code_q   <= '0;
      cnt      <= '0;
      bits     <= '0;
      host     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      wr_drop  <= 1'b0;
      code_out <= '0;
      sclk     <= 1'b0;
      sdi      <= 1'b0;
      ld_n     <= 1'b1;
    end else begin
      done    <= 1'b0;
      wr_drop <= wr && busy;
      unique case (state)
        IDLE: begin
          sclk <= 1'b0;
          ld_n <= 1'b1;
          if (wr) begin
            shreg  <= wdata;
            code_q <= wdata;
            sdi    <= wdata[DATA_W-1];
            host   <= 1'b1;
          end else if (go_ref) begin
            shreg  <= code_out;
            code_q <= code_out;
            sdi    <= code_out[DATA_W-1];
            host   <= 1'b0;
          end
          if (wr || go_ref) begin
            state <= SETUP;
            busy  <= 1'b1;
            bits  <= BITS_INIT;
            cnt   <= '0;
          end
        end
        SETUP: begin
          if (cnt == DIV_LAST) begin
            cnt   <= '0;
            sclk  <= 1'b1;
            state <= HIGH;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        HIGH: begin
          if (cnt == DIV_LAST) begin
            cnt   <= '0;
            sclk  <= 1'b0;
            shreg <= nxt;
            bits  <= bits - BW'(1);
            if (bits == BITS_ONE) begin
              sdi   <= 1'b0;
              ld_n  <= 1'b0;
              state <= LOAD;
            end else begin
              sdi   <= nxt[DATA_W-1];
              state <= SETUP;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        LOAD: begin
          if (cnt == LD_LAST) begin
            cnt   <= '0;
            ld_n  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
            if (host) begin
              done     <= 1'b1;
              code_out <= code_q;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tub_thresh_dac_loader.sv
// Bench for tub_thresh_dac_loader: random host writes vs. a
// transaction-level model, plus directed corner cases.
module tb_tub_thresh_dac_loader;

  localparam int DW  = 12;
  localparam int DIV = 4;
  localparam int LDC = 2;
  localparam int T   = 2 * DIV * DW + LDC;

  logic          clk = 1'b0;
  logic          reset, wr, wr1;
  logic [DW-1:0] wdata, wdata1;
  logic          busy, done, wr_drop, sclk, sdi, ld_n;
  logic [DW-1:0] code_out;
  logic          busy1, done1, wr_drop1, sclk1, sdi1, ld_n1;
  logic [DW-1:0] code_out1;

  always #5 clk = ~clk;

  tub_thresh_dac_loader #(.DATA_W(DW), .DIV(DIV), .LD_CYC(LDC)) dut (
    .clk(clk), .reset(reset), .wr(wr), .wdata(wdata),
    .busy(busy), .done(done), .wr_drop(wr_drop),
    .code_out(code_out), .sclk(sclk), .sdi(sdi), .ld_n(ld_n)
  );

  tub_thresh_dac_loader #(.DATA_W(DW), .DIV(1), .LD_CYC(LDC)) dut1 (
    .clk(clk), .reset(reset), .wr(wr1), .wdata(wdata1),
    .busy(busy1), .done(done1), .wr_drop(wr_drop1),
    .code_out(code_out1), .sclk(sclk1), .sdi(sdi1), .ld_n(ld_n1)
  );

  int ncmp = 0;
  int nerr = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    ncmp++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // transaction model: remaining busy cycles, code in flight, loaded code
  int            rem = 0;
  logic [DW-1:0] pend = '0, mcode = '0;
  logic          edone = 0, edrop = 0, ebusy = 0;

  // serial-side monitor state
  logic [DW-1:0] rx = '0;
  int            nbits = 0, hi_run = 0, ld_run = 0, bz_run = 0;
  int            ld_pulses = 0;
  logic          p_sclk = 0, p_sdi = 0, p_ldn = 1, p_busy = 0;

  task automatic cyc(input logic w, input logic [DW-1:0] d,
                     input logic r);
    wr = w; wdata = d; reset = r;
    if (r) begin
      rem = 0; mcode = '0; edone = 0; edrop = 0;
    end else begin
      edrop = w && (rem > 0);
      edone = 0;
      if (rem > 0) begin
        rem--;
        if (rem == 0) begin
          edone = 1;
          mcode = pend;
        end
      end else if (w) begin
        rem = T;
        pend = d;
      end
    end
    ebusy = (rem > 0);
    @(posedge clk);
    @(negedge clk);
    check("busy", busy, ebusy);
    check("done", done, edone);
    check("wr_drop", wr_drop, edrop);
    check("code_out", code_out, mcode);
    if (r) begin
      check("rst_sclk", sclk, 0);
      check("rst_sdi", sdi, 0);
      check("rst_ld_n", ld_n, 1);
      rx = '0; nbits = 0; hi_run = 0; ld_run = 0; bz_run = 0;
    end else begin
      if (sclk && !p_sclk) begin
        rx = {rx[DW-2:0], sdi};
        nbits++;
      end
      if (sclk && p_sclk) check("sdi_hold", sdi, p_sdi);
      if (sclk) hi_run++;
      else if (p_sclk) begin
        check("sclk_high_len", hi_run, DIV);
        hi_run = 0;
      end
      if (!ld_n) ld_run++;
      if (ld_n && !p_ldn) begin
        check("ld_len", ld_run, LDC);
        check("dac_word", rx, pend);
        check("dac_nbits", nbits, DW);
        ld_pulses++;
        ld_run = 0;
        nbits = 0;
      end
      if (busy) bz_run++;
      else if (p_busy) begin
        check("busy_len", bz_run, T);
        bz_run = 0;
      end
    end
    p_sclk = sclk; p_sdi = sdi; p_ldn = ld_n; p_busy = busy;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, '0, 1'b0);
  endtask

  int            found, lp0, b1, nr, lastr, imin, imax, nd1;
  logic [DW-1:0] rx1;
  logic          ps1, lastbit;

  initial begin
    wr = 0; wdata = '0; reset = 1; wr1 = 0; wdata1 = '0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1);

    // basic transfer
    cyc(1'b1, 12'hA5C, 1'b0);
    idle(T + 10);
    check("ld_pulses_a5c", ld_pulses, 1);

    // second write while busy is dropped
    cyc(1'b1, 12'hFFF, 1'b0);
    idle(9);
    cyc(1'b1, 12'h000, 1'b0);
    idle(T + 5);
    check("code_fff", code_out, 12'hFFF);

    // write in the done cycle starts the next transfer at once
    cyc(1'b1, 12'h123, 1'b0);
    found = 0;
    for (int i = 0; i < T + 20 && !found; i++) begin
      cyc(1'b0, '0, 1'b0);
      if (done) found = 1;
    end
    check("done_seen_123", found, 1);
    cyc(1'b1, 12'h456, 1'b0);
    check("busy_after_done_wr", busy, 1);
    idle(T + 5);
    check("code_456", code_out, 12'h456);

    // reset in the middle of a transfer
    cyc(1'b1, 12'h800, 1'b0);
    found = 0;
    for (int i = 0; i < T && !found; i++) begin
      cyc(1'b0, '0, 1'b0);
      if (nbits == 5) found = 1;
    end
    check("rise5_seen", found, 1);
    lp0 = ld_pulses;
    cyc(1'b0, '0, 1'b1);
    check("abort_busy", busy, 0);
    check("abort_code", code_out, 0);
    idle(T + 10);
    check("abort_no_load", ld_pulses, lp0);

    // random host traffic
    for (int i = 0; i < 1500; i++)
      cyc(($urandom % 100) < 4, DW'($urandom), 1'b0);
    idle(T + 5);

    // DIV=1 instance
    wr1 = 1; wdata1 = 12'h001;
    b1 = 0; nr = 0; lastr = -1; imin = 99; imax = 0; nd1 = 0;
    rx1 = '0; ps1 = 0; lastbit = 0;
    for (int i = 0; i < 60; i++) begin
      cyc(1'b0, '0, 1'b0);
      wr1 = 0;
      if (busy1) b1++;
      if (done1) nd1++;
      if (sclk1 && !ps1) begin
        rx1 = {rx1[DW-2:0], sdi1};
        lastbit = sdi1;
        nr++;
        if (lastr >= 0) begin
          if (i - lastr < imin) imin = i - lastr;
          if (i - lastr > imax) imax = i - lastr;
        end
        lastr = i;
      end
      ps1 = sclk1;
    end
    check("div1_busy_len", b1, 26);
    check("div1_rises", nr, DW);
    check("div1_word", rx1, 12'h001);
    check("div1_last_bit", lastbit, 1);
    check("div1_period_min", imin, 2);
    check("div1_period_max", imax, 2);
    check("div1_done_cnt", nd1, 1);
    check("div1_code", code_out1, 12'h001);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
